video_palout: RTL and testbench

//  Consumes the 8-bit pixel plex produced by the render stage and converts it to RGB.
//  In lo-res, the plex is one palette index per pixel.
//  In hi-res, the plex is two 4-bit pixels: the high nibble is the earlier pixel, the low nibble the later one.

---
 rtl/video_palout_pkg.sv | 19 +
 rtl/video_palout_cram.sv | 27 ++
 rtl/video_palout.sv | 100 ++++++++++
 tb/tb_video_palout.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/video_palout_pkg.sv
// Shared constants for the palette output stage: CRAM geometry, colour field
// positions and the strobe-to-RGB latency.
package video_palout_pkg;

    localparam int CRAM_AW = 8;
    localparam int CRAM_DW = 16;
    localparam int PAL_LAT = 2;
    localparam int COMP_W  = 5;

    localparam int R_LSB = 10;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    function automatic logic [COMP_W-1:0] cram_comp(input logic [CRAM_DW-1:0] d,
                                                    input int lsb);
        return d[lsb +: COMP_W];
    endfunction

endpackage

// File: rtl/video_palout_cram.sv
// 256x16 colour RAM: one write port and one enabled synchronous read port on
// the same clock. A same-address read and write returns the old contents.
module video_palout_cram
    import video_palout_pkg::*;
(
    input  logic               clk,
    input  logic               i_we,
    input  logic [CRAM_AW-1:0] i_waddr,
    input  logic [CRAM_DW-1:0] i_wdata,
    input  logic               i_re,
    input  logic [CRAM_AW-1:0] i_raddr,
    output logic [CRAM_DW-1:0] o_rdata
);

    logic [CRAM_DW-1:0] r_mem [0:(1<<CRAM_AW)-1];

    // Both accesses in one block with non-blocking updates gives read-before-write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/video_palout.sv
// Palette output stage: turns the render-stage pixel plex (lo-res index or two
// hi-res nibbles) into registered RGB through the CRAM, with blanking.
module video_palout
    import video_palout_pkg::*;
#(
    parameter int CW      = 5,
    parameter int BLK_RGB = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                c3,
    input  logic                c1,
    input  logic                hires,
    input  logic [3:0]          hpalsel,
    input  logic [7:0]          vplex_in,
    input  logic                blank_in,
    input  logic                cram_we,
    input  logic [CRAM_AW-1:0]  cram_addr,
    input  logic [CRAM_DW-1:0]  cram_data,
    output logic [CW-1:0]       vred,
    output logic [CW-1:0]       vgrn,
    output logic [CW-1:0]       vblu,
    output logic                vblank
);

    localparam logic [CW-1:0] BLK = CW'(BLK_RGB);

    logic [7:0]          r_plex;
    logic                r_mode;
    logic [3:0]          r_hpal;
    logic                r_blank;
    logic [CRAM_AW-1:0]  r_idx;
    logic                r_rd_en;
    logic                r_blank_s1;
    logic                w_c1;
    logic [CRAM_DW-1:0]  w_rdata;
    logic [COMP_W-1:0]   w_r;
    logic [COMP_W-1:0]   w_g;
    logic [COMP_W-1:0]   w_b;

    // c1 only matters for the second half of a hi-res pixel, and loses to c3.
    assign w_c1 = c1 && !c3 && r_mode;

    // Stage 0: capture the plex and pick the palette index on each strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plex  <= '0;
            r_mode  <= 1'b0;
            r_hpal  <= '0;
            r_blank <= 1'b1;
            r_idx   <= '0;
            r_rd_en <= 1'b0;
        end else begin
            r_rd_en <= c3 || w_c1;
            if (c3) begin
                r_plex  <= vplex_in;
                r_mode  <= hires;
                r_hpal  <= hpalsel;
                r_blank <= blank_in;
                r_idx   <= hires ? {hpalsel, vplex_in[7:4]} : vplex_in;
            end else if (w_c1) begin
                r_idx   <= {r_hpal, r_plex[3:0]};
            end
        end
    end

    // Stage 1: the read is enabled only after a strobe so the pixel is held
    // between strobes even if the CPU rewrites its entry.
    video_palout_cram u_cram (
        .clk     (clk),
        .i_we    (cram_we),
        .i_waddr (cram_addr),
        .i_wdata (cram_data),
        .i_re    (r_rd_en),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign w_r = cram_comp(w_rdata, R_LSB);
    assign w_g = cram_comp(w_rdata, G_LSB);
    assign w_b = cram_comp(w_rdata, B_LSB);

    // Stage 2: blank travels alongside the read data, then muxes the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank_s1 <= 1'b1;
            vblank     <= 1'b1;
            vred       <= BLK;
            vgrn       <= BLK;
            vblu       <= BLK;
        end else begin
            r_blank_s1 <= r_blank;
            vblank     <= r_blank_s1;
            vred       <= r_blank_s1 ? BLK : w_r[COMP_W-1 -: CW];
            vgrn       <= r_blank_s1 ? BLK : w_g[COMP_W-1 -: CW];
            vblu       <= r_blank_s1 ? BLK : w_b[COMP_W-1 -: CW];
        end
    end

endmodule

// File: tb/tb_video_palout.sv
// Directed bench for video_palout: lo-res, hi-res halves, palette-select
// sampling, CRAM collision, blanking and mid-line reset.
module tb_video_palout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c3, c1, hires, blank_in, cram_we;
    logic [3:0]  hpalsel;
    logic [7:0]  vplex_in, cram_addr;
    logic [15:0] cram_data;
    logic [4:0]  vred, vgrn, vblu;
    logic        vblank;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    video_palout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c3        (c3),
        .c1        (c1),
        .hires     (hires),
        .hpalsel   (hpalsel),
        .vplex_in  (vplex_in),
        .blank_in  (blank_in),
        .cram_we   (cram_we),
        .cram_addr (cram_addr),
        .cram_data (cram_data),
        .vred      (vred),
        .vgrn      (vgrn),
        .vblu      (vblu),
        .vblank    (vblank)
    );

    // Expected RGB bus for a CRAM word with CW=5: bit 15 dropped.
    function automatic logic [15:0] rgb_of(input logic [15:0] d);
        return {1'b0, d[14:0]};
    endfunction

    function automatic logic [15:0] rgb_now();
        return {1'b0, vred, vgrn, vblu};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        cram_we = 1'b1; cram_addr = a; cram_data = d;
        @(negedge clk);
        cram_we = 1'b0;
    endtask

    // One-cycle strobe driven from a negedge; returns at the following negedge.
    task automatic pulse(input bit is_c3, input bit is_c1, input logic [7:0] plex,
                         input bit hr, input logic [3:0] pal, input bit bl);
        @(negedge clk);
        c3 = is_c3; c1 = is_c1; vplex_in = plex; hires = hr; hpalsel = pal; blank_in = bl;
        @(negedge clk);
        c3 = 1'b0; c1 = 1'b0;
    endtask

    // After pulse(): one clk later the old pixel remains, two clk later the new one shows.
    task automatic expect_px(input string tag, input logic [15:0] old_rgb, input bit old_bl,
                             input logic [15:0] new_rgb, input bit new_bl);
        @(negedge clk);
        chk({tag, "_hold_rgb"}, rgb_now(), old_rgb);
        chk({tag, "_hold_blank"}, {15'd0, vblank}, {15'd0, old_bl});
        @(negedge clk);
        chk({tag, "_rgb"}, rgb_now(), new_rgb);
        chk({tag, "_blank"}, {15'd0, vblank}, {15'd0, new_bl});
    endtask

    initial begin
        rst_n = 1'b0; c3 = 0; c1 = 0; hires = 0; blank_in = 0; cram_we = 0;
        hpalsel = 0; vplex_in = 0; cram_addr = 0; cram_data = 0;
        repeat (3) @(negedge clk);
        chk("reset_blank", {15'd0, vblank}, 16'd1);
        chk("reset_rgb", rgb_now(), 16'd0);
        rst_n = 1'b1;

        wr(8'h5A, 16'h7C00);
        wr(8'hA3, 16'h1234);
        wr(8'hAC, 16'h8421);
        wr(8'h5F, 16'h2BCD);
        wr(8'h10, 16'h001F);
        wr(8'h33, 16'h3FFF);
        chk("idle_blank", {15'd0, vblank}, 16'd1);

        // Lo-res pixel, then a c1 that must not disturb it.
        pulse(1, 0, 8'h5A, 0, 4'h0, 0);
        expect_px("lores", 16'h0000, 1, rgb_of(16'h7C00), 0);
        pulse(0, 1, 8'h00, 0, 4'h0, 0);
        repeat (3) @(negedge clk);
        chk("lores_c1_hold", rgb_now(), rgb_of(16'h7C00));

        // Hi-res: first half A3, second half AC.
        pulse(1, 0, 8'h3C, 1, 4'hA, 0);
        expect_px("hires_h1", rgb_of(16'h7C00), 0, rgb_of(16'h1234), 0);
        pulse(0, 1, 8'h00, 1, 4'hA, 0);
        expect_px("hires_h2", rgb_of(16'h1234), 0, rgb_of(16'h8421), 0);

        // hpalsel/hires change between c3 and c1 only take effect at next c3.
        pulse(1, 0, 8'h3C, 1, 4'hA, 0);
        expect_px("palsel_h1", rgb_of(16'h8421), 0, rgb_of(16'h1234), 0);
        pulse(0, 1, 8'h00, 0, 4'h5, 0);
        expect_px("palsel_h2", rgb_of(16'h1234), 0, rgb_of(16'h8421), 0);
        pulse(1, 0, 8'hF3, 1, 4'h5, 0);
        expect_px("palsel_next", rgb_of(16'h8421), 0, rgb_of(16'h2BCD), 0);

        // c3 and c1 together: c3 wins, c1 ignored.
        pulse(1, 1, 8'h3C, 1, 4'hA, 0);
        expect_px("c3c1", rgb_of(16'h2BCD), 0, rgb_of(16'h1234), 0);
        @(negedge clk);
        chk("c3c1_after", rgb_now(), rgb_of(16'h1234));

        // Collision: write 0x10 on the same clk that reads it.
        pulse(1, 0, 8'h10, 0, 4'h0, 0);
        cram_we = 1'b1; cram_addr = 8'h10; cram_data = 16'h03E0;
        @(negedge clk);
        cram_we = 1'b0;
        chk("coll_hold", rgb_now(), rgb_of(16'h1234));
        @(negedge clk);
        chk("coll_old", rgb_now(), rgb_of(16'h001F));
        pulse(1, 0, 8'h10, 0, 4'h0, 0);
        expect_px("coll_new", rgb_of(16'h001F), 0, rgb_of(16'h03E0), 0);

        // Blanking in and out.
        pulse(1, 0, 8'h33, 0, 4'h0, 1);
        expect_px("blank_on", rgb_of(16'h03E0), 0, 16'h0000, 1);
        pulse(1, 0, 8'h33, 0, 4'h0, 0);
        expect_px("blank_off", 16'h0000, 1, rgb_of(16'h3FFF), 0);

        // Asynchronous reset mid-pixel.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_blank", {15'd0, vblank}, 16'd1);
        chk("async_rst_rgb", rgb_now(), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_blank", {15'd0, vblank}, 16'd1);
        pulse(1, 0, 8'h5A, 0, 4'h0, 0);
        expect_px("post_rst", 16'h0000, 1, rgb_of(16'h7C00), 0);
        pulse(1, 0, 8'h33, 0, 4'h0, 0);
        expect_px("post_rst_cram", rgb_of(16'h7C00), 0, rgb_of(16'h3FFF), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
